// File: rtl/ctx_conflict_sched.sv
// ctx_conflict_sched: splits 8-lane pixel groups that carry duplicate
// low contexts (ql) into conflict-free issue cycles. This protects the
// downstream scatter stage, which can only place one lane per context.
// The lowest lane wins each context, and remaining duplicates issue in
// later cycles in ascending lane order.
module ctx_conflict_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vl,
    output logic             o_rdy,
    input  logic             i_et,
    input  logic [7:0]       i_x  [1:8],
    input  logic [7:0]       i_px [1:8],
    input  logic             i_s  [1:8],
    input  logic [4:0]       i_qh [1:8],
    input  logic [3:0]       i_ql [1:8],
    input  logic [13:0]      i_rl,
    output logic             o_vl,
    output logic             o_et,
    output logic [7:0]       o_x  [1:8],
    output logic [7:0]       o_px [1:8],
    output logic             o_s  [1:8],
    output logic [4:0]       o_qh [1:8],
    output logic [3:0]       o_ql [1:8],
    output logic [13:0]      o_rl,
    output logic [CNT_W-1:0] o_conf_cnt
);

    typedef enum logic {IDLE, SPLIT} state_t;

    // control state (reset)
    state_t           state_q, state_d;
    logic [8:1]       pend_q, pend_d;
    logic             vl_q, vl_d;
    logic             et_q, et_d;
    logic [3:0]       oql_q [1:8];
    logic [3:0]       oql_d [1:8];
    logic [13:0]      rl_q, rl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // captured group (no reset, contents are don't-care after reset)
    logic [7:0]       gx_q  [1:8];
    logic [7:0]       gx_d  [1:8];
    logic [7:0]       gpx_q [1:8];
    logic [7:0]       gpx_d [1:8];
    logic             gs_q  [1:8];
    logic             gs_d  [1:8];
    logic [4:0]       gqh_q [1:8];
    logic [4:0]       gqh_d [1:8];
    logic [3:0]       gql_q [1:8];
    logic [3:0]       gql_d [1:8];
    logic             get_q, get_d;

    // scratch
    logic             acc;
    logic [3:0]       nql  [1:8];
    logic [3:0]       cql  [1:8];
    logic [8:1]       cmask;
    logic [8:1]       iss;
    logic [8:1]       rem;

    assign o_rdy      = (state_q == IDLE);
    assign o_vl       = vl_q;
    assign o_et       = et_q;
    assign o_ql       = oql_q;
    assign o_rl       = rl_q;
    assign o_conf_cnt = cnt_q;
    assign o_x        = gx_q;
    assign o_px       = gpx_q;
    assign o_s        = gs_q;
    assign o_qh       = gqh_q;

    // issue-set selection and next-state / output computation
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        vl_d    = 1'b0;
        et_d    = 1'b0;
        rl_d    = '0;
        gx_d    = gx_q;
        gpx_d   = gpx_q;
        gs_d    = gs_q;
        gqh_d   = gqh_q;
        gql_d   = gql_q;
        get_d   = get_q;
        acc     = i_vl && (state_q == IDLE);
        cmask   = '0;
        iss     = '0;
        rem     = '0;
        for (int i = 1; i <= 8; i++) begin
            oql_d[i] = 4'hf;
            nql[i]   = (i_ql[i] > 4'd13) ? 4'hf : i_ql[i];
            cql[i]   = 4'hf;
        end

        // candidates: fresh input lanes when accepting, else the pending mask
        for (int i = 1; i <= 8; i++) begin
            if (state_q == IDLE) begin
                cql[i]   = nql[i];
                cmask[i] = acc && (nql[i] != 4'hf);
            end else begin
                cql[i]   = gql_q[i];
                cmask[i] = pend_q[i];
            end
        end

        // a candidate issues only if no lower candidate holds the same ql
        for (int i = 1; i <= 8; i++) begin
            iss[i] = cmask[i];
            for (int j = 1; j < i; j++) begin
                if (cmask[j] && (cql[j] == cql[i])) iss[i] = 1'b0;
            end
        end
        rem = cmask & ~iss;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    gx_d   = i_x;
                    gpx_d  = i_px;
                    gs_d   = i_s;
                    gqh_d  = i_qh;
                    gql_d  = nql;
                    get_d  = i_et;
                    vl_d   = 1'b1;
                    rl_d   = i_rl;
                    pend_d = rem;
                    for (int i = 1; i <= 8; i++) begin
                        if (iss[i]) oql_d[i] = cql[i];
                    end
                    if (rem == '0) et_d = i_et;
                    else           state_d = SPLIT;
                end
            end
            SPLIT: begin
                vl_d   = 1'b1;
                pend_d = rem;
                for (int i = 1; i <= 8; i++) begin
                    if (iss[i]) oql_d[i] = cql[i];
                end
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                if (rem == '0) begin
                    et_d    = get_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            vl_q    <= 1'b0;
            et_q    <= 1'b0;
            rl_q    <= '0;
            cnt_q   <= '0;
            for (int i = 1; i <= 8; i++) oql_q[i] <= 4'hf;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            vl_q    <= vl_d;
            et_q    <= et_d;
            rl_q    <= rl_d;
            cnt_q   <= cnt_d;
            oql_q   <= oql_d;
        end
    end

    // captured group data; held outside acceptance
    always_ff @(posedge clk) begin
        gx_q  <= gx_d;
        gpx_q <= gpx_d;
        gs_q  <= gs_d;
        gqh_q <= gqh_d;
        gql_q <= gql_d;
        get_q <= get_d;
    end

endmodule

// File: tb/tb_ctx_conflict_sched.sv
// Bench for ctx_conflict_sched: a rank-based reference model (lane issues
// in cycle rank+1, rank = count of lower valid lanes with the same ql)
// checked every cycle, plus directed groups with literal expectations.
module tb_ctx_conflict_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vl, i_et, o_rdy, o_vl, o_et;
    logic [7:0]  i_x  [1:8];
    logic [7:0]  i_px [1:8];
    logic        i_s  [1:8];
    logic [4:0]  i_qh [1:8];
    logic [3:0]  i_ql [1:8];
    logic [13:0] i_rl, o_rl;
    logic [7:0]  o_x  [1:8];
    logic [7:0]  o_px [1:8];
    logic        o_s  [1:8];
    logic [4:0]  o_qh [1:8];
    logic [3:0]  o_ql [1:8];
    logic [15:0] o_conf_cnt;

    always #5 clk = ~clk;

    ctx_conflict_sched #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_vl(i_vl), .o_rdy(o_rdy), .i_et(i_et),
        .i_x(i_x), .i_px(i_px), .i_s(i_s), .i_qh(i_qh), .i_ql(i_ql), .i_rl(i_rl),
        .o_vl(o_vl), .o_et(o_et), .o_x(o_x), .o_px(o_px), .o_s(o_s), .o_qh(o_qh),
        .o_ql(o_ql), .o_rl(o_rl), .o_conf_cnt(o_conf_cnt)
    );

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // packed views of lane arrays
    logic [31:0] in_ql_p, out_ql_p;
    logic [63:0] in_x_p, out_x_p, in_px_p, out_px_p;
    logic [7:0]  in_s_p, out_s_p;
    logic [39:0] in_qh_p, out_qh_p;
    always_comb begin
        in_ql_p = '0; out_ql_p = '0; in_x_p = '0; out_x_p = '0;
        in_px_p = '0; out_px_p = '0; in_s_p = '0; out_s_p = '0;
        in_qh_p = '0; out_qh_p = '0;
        for (int i = 1; i <= 8; i++) begin
            in_ql_p[4*(i-1) +: 4]  = i_ql[i];
            out_ql_p[4*(i-1) +: 4] = o_ql[i];
            in_x_p[8*(i-1) +: 8]   = i_x[i];
            out_x_p[8*(i-1) +: 8]  = o_x[i];
            in_px_p[8*(i-1) +: 8]  = i_px[i];
            out_px_p[8*(i-1) +: 8] = o_px[i];
            in_s_p[i-1]            = i_s[i];
            out_s_p[i-1]           = o_s[i];
            in_qh_p[5*(i-1) +: 5]  = i_qh[i];
            out_qh_p[5*(i-1) +: 5] = o_qh[i];
        end
    end

    typedef struct {
        logic        vl, et, dv, get;
        logic [13:0] rl;
        logic [31:0] ql, gql;
        logic [15:0] cnt;
        logic [63:0] x, px;
        logic [7:0]  s;
        logic [39:0] qh;
        int          cur, rem;
    } model_t;
    model_t m;

    function automatic bit lane_ok(input logic [3:0] q);
        return q <= 4'd13;
    endfunction

    // rank of lane i: number of lower valid lanes with the same ql
    function automatic int rank_of(input logic [31:0] q, input int i);
        int r = 0;
        for (int j = 1; j < i; j++)
            if (lane_ok(q[4*(j-1) +: 4]) && q[4*(j-1) +: 4] == q[4*(i-1) +: 4]) r++;
        return r;
    endfunction

    function automatic logic [31:0] issue_vec(input logic [31:0] q, input int n);
        logic [31:0] v = 32'hffffffff;
        for (int i = 1; i <= 8; i++)
            if (lane_ok(q[4*(i-1) +: 4]) && rank_of(q, i) == n - 1)
                v[4*(i-1) +: 4] = q[4*(i-1) +: 4];
        return v;
    endfunction

    function automatic int cycles_of(input logic [31:0] q);
        int k = 1;
        for (int i = 1; i <= 8; i++)
            if (lane_ok(q[4*(i-1) +: 4]) && rank_of(q, i) + 1 > k) k = rank_of(q, i) + 1;
        return k;
    endfunction

    function automatic model_t step(input model_t c, input logic r, input logic v);
        model_t n = c;
        if (r) begin
            n.vl = 0; n.et = 0; n.rl = '0; n.ql = 32'hffffffff; n.cnt = '0;
            n.rem = 0; n.dv = 0;
        end else if (c.rem > 0) begin
            n.cur = c.cur + 1;
            n.rem = c.rem - 1;
            n.vl  = 1; n.rl = '0;
            n.ql  = issue_vec(c.gql, n.cur);
            n.et  = (n.rem == 0) ? c.get : 1'b0;
            if (c.cnt != 16'hffff) n.cnt = c.cnt + 16'd1;
        end else if (v) begin
            n.gql = in_ql_p; n.get = i_et;
            n.cur = 1;
            n.rem = cycles_of(in_ql_p) - 1;
            n.vl  = 1; n.rl = i_rl;
            n.ql  = issue_vec(in_ql_p, 1);
            n.et  = (n.rem == 0) ? i_et : 1'b0;
            n.x = in_x_p; n.px = in_px_p; n.s = in_s_p; n.qh = in_qh_p; n.dv = 1;
        end else begin
            n.vl = 0; n.et = 0; n.rl = '0; n.ql = 32'hffffffff;
        end
        return n;
    endfunction

    // reference model advances on the same edge the DUT samples
    always @(posedge clk) m <= step(m, rst, i_vl);

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rdy", o_rdy, m.rem == 0);
            chk("m_vl", o_vl, m.vl);
            chk("m_et", o_et, m.et);
            chk("m_ql", out_ql_p, m.ql);
            chk("m_rl", o_rl, m.rl);
            chk("m_cnt", o_conf_cnt, m.cnt);
            if (m.dv) begin
                chk("m_x", out_x_p, m.x);
                chk("m_px", out_px_p, m.px);
                chk("m_s", out_s_p, m.s);
                chk("m_qh", out_qh_p, m.qh);
            end
        end
    end

    task automatic set_group(input logic [31:0] q, input logic [13:0] rl, input logic et,
                             input logic [7:0] seed);
        for (int i = 1; i <= 8; i++) begin
            i_ql[i] = q[4*(i-1) +: 4];
            i_x[i]  = seed + 8'(i);
            i_px[i] = seed + 8'(2 * i + 1);
            i_s[i]  = 1'(i % 2);
            i_qh[i] = 5'(seed) + 5'(i);
        end
        i_rl = rl; i_et = et; i_vl = 1'b1;
    endtask

    // called at a negedge with a group set up; returns at the negedge of issue cycle 1
    task automatic send();
        int t = 0;
        while (!o_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) chk("rdy_timeout", 0, 1);
        @(negedge clk);
        i_vl = 1'b0;
    endtask

    logic [31:0] e;

    initial begin
        rst = 1'b1; i_vl = 1'b0;
        set_group(32'hffffffff, 14'h0, 1'b0, 8'h00);
        i_vl = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_vl", o_vl, 0);
        chk("rst_rdy", o_rdy, 1);
        chk("rst_cnt", o_conf_cnt, 0);
        chk("rst_ql", out_ql_p, 32'hffffffff);
        rst = 1'b0;
        @(negedge clk);

        // distinct contexts
        set_group(32'h76543210, 14'h0005, 1'b1, 8'h10);
        send();
        chk("dist_ql", out_ql_p, 32'h76543210);
        chk("dist_rl", o_rl, 14'h0005);
        chk("dist_et", o_et, 1);
        chk("dist_rdy", o_rdy, 1);
        chk("dist_cnt", o_conf_cnt, 0);
        @(negedge clk);

        // pairwise collisions
        set_group(32'h99775533, 14'h0003, 1'b1, 8'h20);
        send();
        chk("pair_c1_ql", out_ql_p, 32'hf9f7f5f3);
        chk("pair_c1_rl", o_rl, 14'h0003);
        chk("pair_c1_et", o_et, 0);
        chk("pair_c1_rdy", o_rdy, 0);
        @(negedge clk);
        chk("pair_c2_ql", out_ql_p, 32'h9f7f5f3f);
        chk("pair_c2_rl", o_rl, 0);
        chk("pair_c2_et", o_et, 1);
        chk("pair_cnt", o_conf_cnt, 1);
        @(negedge clk);

        // all lanes on one context
        set_group(32'h22222222, 14'h0, 1'b1, 8'h30);
        send();
        for (int n = 1; n <= 8; n++) begin
            e = 32'hffffffff;
            e[4*(n-1) +: 4] = 4'h2;
            chk("same_ql", out_ql_p, e);
            chk("same_et", o_et, n == 8);
            if (n < 8) @(negedge clk);
        end
        chk("same_cnt", o_conf_cnt, 8);
        @(negedge clk);

        // invalid lanes
        set_group(32'hff01f1fe, 14'h0, 1'b1, 8'h50);
        send();
        chk("inv_c1_ql", out_ql_p, 32'hff0ff1ff);
        chk("inv_c1_et", o_et, 0);
        @(negedge clk);
        chk("inv_c2_ql", out_ql_p, 32'hfff1ffff);
        chk("inv_c2_et", o_et, 1);
        chk("inv_cnt", o_conf_cnt, 9);
        @(negedge clk);

        // all-invalid group still takes one issue cycle
        set_group(32'hffffffff, 14'h0, 1'b1, 8'h60);
        send();
        chk("allinv_vl", o_vl, 1);
        chk("allinv_et", o_et, 1);
        chk("allinv_ql", out_ql_p, 32'hffffffff);
        chk("allinv_rdy", o_rdy, 1);
        @(negedge clk);

        // back-to-back: A (k=3) then B (k=1) with i_vl held
        set_group(32'h53210444, 14'h3fff, 1'b0, 8'h40);
        @(negedge clk);
        set_group(32'h76543210, 14'h0011, 1'b1, 8'h80);
        chk("b2b_c1_ql", out_ql_p, 32'h53210ff4);
        chk("b2b_c1_rl", o_rl, 14'h3fff);
        chk("b2b_c1_rdy", o_rdy, 0);
        chk("b2b_c1_x1", o_x[1], 8'h41);
        @(negedge clk);
        chk("b2b_c2_ql", out_ql_p, 32'hffffff4f);
        chk("b2b_c2_rdy", o_rdy, 0);
        @(negedge clk);
        chk("b2b_c3_ql", out_ql_p, 32'hfffff4ff);
        chk("b2b_c3_et", o_et, 0);
        chk("b2b_c3_rdy", o_rdy, 1);
        chk("b2b_c3_x1", o_x[1], 8'h41);
        @(negedge clk);
        i_vl = 1'b0;
        chk("b2b_c4_vl", o_vl, 1);
        chk("b2b_c4_ql", out_ql_p, 32'h76543210);
        chk("b2b_c4_rl", o_rl, 14'h0011);
        chk("b2b_c4_et", o_et, 1);
        chk("b2b_c4_x1", o_x[1], 8'h81);
        chk("b2b_cnt", o_conf_cnt, 11);
        @(negedge clk);
        chk("b2b_idle_vl", o_vl, 0);

        // reset during the 8-way split
        set_group(32'h22222222, 14'h0, 1'b1, 8'h90);
        send();
        @(negedge clk);
        chk("rsplit_c2_ql", out_ql_p, 32'hffffff2f);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsplit_vl", o_vl, 0);
        chk("rsplit_ql", out_ql_p, 32'hffffffff);
        chk("rsplit_cnt", o_conf_cnt, 0);
        chk("rsplit_rdy", o_rdy, 1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("rsplit_quiet_vl", o_vl, 0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
